// File: rtl/auth_pkg.sv
// auth_pkg: shared states and command codes for the rider-authorization gate
package auth_pkg;
   typedef enum logic [1:0] {OFF, PWR1, PWR2} auth_state_t;
   localparam logic [7:0] CMD_GO   = 8'h47;
   localparam logic [7:0] CMD_STOP = 8'h53;
   typedef enum {IDLE, RECV} rx_state_t;
endpackage

// File: rtl/auth_blk_uart_rx.sv
// uart_rx: 8N1 receiver, mid-bit sampling; stop-bit check enabled by AUTH_FRAME_ERR_EN
module uart_rx
   import auth_pkg::*;
#(
   parameter int BAUD_DIV = 2604
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       RX,
   input  logic       clr_rdy,
   output logic [7:0] rx_data,
   output logic       rx_rdy
);
   localparam int CW = $clog2(BAUD_DIV + 1);
   logic          rx_ff1, rx_s, rx_prev;
   rx_state_t     state;
   logic [CW-1:0] cnt;
   logic [3:0]    bit_cnt;
   logic [9:0]    shreg;
   logic          fall, tick, last, done;
   logic          unused_lsb;
   assign unused_lsb = shreg[0];
   // A start edge needs the line high beforehand, so a held-low break yields one frame only.
   assign fall = rx_prev & ~rx_s;
   assign tick = (state == RECV) && (cnt == CW'(1));
   assign last = tick && (bit_cnt == 4'd9);
`ifdef AUTH_FRAME_ERR_EN
   assign done = last & rx_s;
`else
   assign done = last;
`endif
   // Double-flop the pin plus one more stage for falling-edge detection; idle-high preset.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {rx_ff1, rx_s, rx_prev} <= 3'b111;
      else        {rx_ff1, rx_s, rx_prev} <= {RX, rx_ff1, rx_s};
   // Frame sequencer: half-bit delay to mid start bit, then one sample per bit time.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
      end else if (state == IDLE) begin
         if (fall) begin
            state   <= RECV;
            cnt     <= CW'(BAUD_DIV / 2);
            bit_cnt <= '0;
         end
      end else if (tick) begin
         shreg   <= {rx_s, shreg[9:1]};
         cnt     <= CW'(BAUD_DIV);
         bit_cnt <= bit_cnt + 4'd1;
         if (last) state <= IDLE;
      end else begin
         cnt <= cnt - CW'(1);
      end
   // Byte hold register and ready flag; the consumer clears ready via clr_rdy.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rx_data <= '0;
         rx_rdy  <= 1'b0;
      end else begin
         rx_data <= done ? shreg[9:2] : rx_data;
         rx_rdy  <= done ? 1'b1 : (clr_rdy ? 1'b0 : rx_rdy);
      end
endmodule

// File: rtl/auth_blk.sv
// auth_blk: UART-commanded power authorization (G powers up, S powers down once rider is off); AUTH_FRAME_ERR_EN drops bad-stop frames
module auth_blk
   import auth_pkg::*;
#(
   parameter int BAUD_DIV = 2604
) (
   input  logic clk,
   input  logic rst_n,
   input  logic RX,
   input  logic rider_off,
   output logic pwr_up
);
   logic [7:0]  rx_data;
   logic        rx_rdy, go, stop;
   auth_state_t state, nxt;
   // Ready is consumed the cycle it appears, giving a single-cycle pulse.
   uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
      .clk    (clk),
      .rst_n  (rst_n),
      .RX     (RX),
      .clr_rdy(rx_rdy),
      .rx_data(rx_data),
      .rx_rdy (rx_rdy)
   );
   assign go   = rx_rdy && (rx_data == CMD_GO);
   assign stop = rx_rdy && (rx_data == CMD_STOP);
   // State register and registered power output mirroring the next state.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state  <= OFF;
         pwr_up <= 1'b0;
      end else begin
         state  <= nxt;
         pwr_up <= (nxt != OFF);
      end
   // Next state: GO beats a coincident rider_off exit from PWR2.
   always_comb begin
      nxt = state;
      unique case (state)
         OFF:     nxt = go ? PWR1 : OFF;
         PWR1:    nxt = stop ? (rider_off ? OFF : PWR2) : PWR1;
         PWR2:    nxt = go ? PWR1 : (rider_off ? OFF : PWR2);
         default: nxt = OFF;
      endcase
   end
endmodule

// File: tb/tb_auth_blk.sv
// tb_auth_blk: directed test of auth_blk with a behavioural 8N1 transmitter driving RX
module tb_auth_blk;
   import auth_pkg::*;
   localparam int BD = 32;
   logic clk = 1'b0;
   logic rst_n, RX, rider_off;
   logic pwr_up;
   int   n_assert = 0;
   int   n_fail = 0;
   int   rdy_cnt = 0;
   int   cnt0;

   auth_blk #(.BAUD_DIV(BD)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .RX       (RX),
      .rider_off(rider_off),
      .pwr_up   (pwr_up)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rdy_cnt <= rdy_cnt + (dut.u_rx.rx_rdy ? 1 : 0);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic bit_time(input logic b, input int n);
      RX = b;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop_bit);
      bit_time(1'b0, BD);
      for (int i = 0; i < 8; i++) bit_time(d[i], BD);
      bit_time(stop_bit, BD);
      RX = 1'b1;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      RX = 1'b1;
      rider_off = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      // 1: reset state, idle line
      check("reset_pwr", pwr_up, 1'b0);
      check("reset_state", dut.state, OFF);
      for (int i = 0; i < 5; i++) begin
         bit_time(1'b1, BD);
         check("idle_pwr", pwr_up, 1'b0);
      end
      check("idle_no_rdy", rdy_cnt, 0);
      // 2: GO powers up, unknown byte ignored
      send_byte(8'h47, 1'b1);
      check("go_pwr", pwr_up, 1'b1);
      check("go_rdy", rdy_cnt, 1);
      send_byte(8'h41, 1'b1);
      check("unk_pwr", pwr_up, 1'b1);
      check("unk_data", dut.u_rx.rx_data, 8'h41);
      // 3: STOP with rider on -> PWR2, then rider_off drops power next clock
      send_byte(8'h53, 1'b1);
      check("stop_on_pwr", pwr_up, 1'b1);
      check("stop_on_state", dut.state, PWR2);
      rider_off = 1'b1;
      @(negedge clk);
      check("rider_off_pwr", pwr_up, 1'b0);
      check("rider_off_state", dut.state, OFF);
      // 4: PWR2 -> GO -> PWR1, then STOP with rider off -> OFF
      rider_off = 1'b0;
      send_byte(8'h47, 1'b1);
      send_byte(8'h53, 1'b1);
      check("pwr2_again", dut.state, PWR2);
      send_byte(8'h47, 1'b1);
      check("pwr2_go_state", dut.state, PWR1);
      rider_off = 1'b1;
      bit_time(1'b1, 3);
      check("pwr1_rider_off_hold", pwr_up, 1'b1);
      send_byte(8'h53, 1'b1);
      check("stop_off_pwr", pwr_up, 1'b0);
      // 5: STOP and 0x00 in OFF are ignored
      send_byte(8'h53, 1'b1);
      check("off_stop_pwr", pwr_up, 1'b0);
      send_byte(8'h00, 1'b1);
      check("off_zero_pwr", pwr_up, 1'b0);
      // break: line held low decodes at most one frame
      rider_off = 1'b0;
      cnt0 = rdy_cnt;
      bit_time(1'b0, 30 * BD);
      bit_time(1'b1, 2 * BD);
`ifdef AUTH_FRAME_ERR_EN
      check("break_frames", rdy_cnt - cnt0, 0);
`else
      check("break_frames", rdy_cnt - cnt0, 1);
      check("break_data", dut.u_rx.rx_data, 8'h00);
`endif
      check("break_pwr", pwr_up, 1'b0);
      // 6: reset during bit 4 of 0x47 aborts the byte
      send_byte(8'h47, 1'b1);
      check("pre_abort_pwr", pwr_up, 1'b1);
      cnt0 = rdy_cnt;
      bit_time(1'b0, BD);
      for (int i = 0; i < 4; i++) bit_time(((8'h47 >> i) & 1) != 0, BD);
      bit_time(1'b0, BD / 2);
      pulse_reset();
      RX = 1'b1;
      check("abort_pwr", pwr_up, 1'b0);
      bit_time(1'b1, 12 * BD);
      check("abort_no_rdy", rdy_cnt - cnt0, 0);
      check("abort_still_off", pwr_up, 1'b0);
      send_byte(8'h47, 1'b1);
      check("post_abort_go", pwr_up, 1'b1);
`ifdef AUTH_FRAME_ERR_EN
      // framing error: bad stop bit drops the byte
      pulse_reset();
      bit_time(1'b1, 2 * BD);
      cnt0 = rdy_cnt;
      send_byte(8'h47, 1'b0);
      bit_time(1'b1, 2 * BD);
      check("ferr_pwr", pwr_up, 1'b0);
      check("ferr_no_rdy", rdy_cnt - cnt0, 0);
      send_byte(8'h47, 1'b1);
      check("ferr_recover", pwr_up, 1'b1);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
